// File: rtl/imem_pkg.sv
// Shared types and helpers for the instruction memory.
package imem_pkg;

  typedef enum logic {
    IMEM_CLEAR,
    IMEM_READY
  } imem_state_t;

  // ARM "mov r0,r0"
  localparam logic [31:0] NOP_WORD = 32'hE1A00000;

  function automatic logic [31:0] byte_swap32(input logic [31:0] w);
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
  endfunction

endpackage

// File: rtl/imem_word_array.sv
// Word storage: one write port, one registered read port, read-first on collision.
module imem_word_array #(
  parameter int unsigned DEPTH_WORDS = 64,
  localparam int unsigned IdxW = $clog2(DEPTH_WORDS)
) (
  input  logic            clk_i,
  input  logic            we_i,
  input  logic [IdxW-1:0] waddr_i,
  input  logic [31:0]     wdata_i,
  input  logic            re_i,
  input  logic [IdxW-1:0] raddr_i,
  output logic [31:0]     rdata_o
);

  logic [31:0] mem_q [DEPTH_WORDS];
  logic [31:0] rdata_q;

  // Non-blocking update gives the old word to a same-edge read.
  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
    if (re_i) rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/imem_sync_rom.sv
// Fetch-stage instruction memory: clear FSM, fault decode, stall hold and endian mux.
// IMEM_INIT_FILE_EN replaces the clear FSM with a file preload.
module imem_sync_rom
  import imem_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 64,
  parameter int unsigned ADDR_W      = 32,
  parameter logic [31:0] FILL_WORD   = NOP_WORD,
  parameter int unsigned BIG_ENDIAN  = 1
) (
  input  logic              clk,
  input  logic              nreset,
  input  logic              fetch_req,
  input  logic [ADDR_W-1:0] fetch_addr,
  input  logic              fetch_stall,
  output logic [31:0]       fetch_data,
  output logic              fetch_valid,
  output logic              fetch_fault,
  input  logic              ld_we,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [31:0]       ld_data,
  output logic              init_done
);

  localparam int unsigned IdxW = $clog2(DEPTH_WORDS);
  localparam logic [ADDR_W-1:0] DepthA = ADDR_W'(DEPTH_WORDS);

  imem_state_t state_q, state_d;
  logic        valid_q, fault_q, fill_sel_q;
  logic        mem_we, mem_re;
  logic [IdxW-1:0] mem_waddr;
  logic [31:0] mem_wdata, rdata;
  logic        fetch_ok, ld_ok, accept;
  logic        unused_ld_lsb;

  assign unused_ld_lsb = ^ld_addr[1:0];

  assign init_done = (state_q == IMEM_READY);
  // Full upper-bit compare so out-of-range addresses never alias onto low words.
  assign fetch_ok  = (fetch_addr[1:0] == 2'b00) && ((fetch_addr >> 2) < DepthA);
  assign ld_ok     = (ld_addr >> 2) < DepthA;
  assign accept    = fetch_req & ~fetch_stall & init_done;
  assign mem_re    = accept & fetch_ok;

`ifndef IMEM_INIT_FILE_EN
  logic [IdxW-1:0] ptr_q;

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      ptr_q <= '0;
    end else if (state_q == IMEM_CLEAR) begin
      ptr_q <= ptr_q + 1'b1;
    end
  end
`endif

  always_comb begin
    state_d   = state_q;
    mem_we    = 1'b0;
    mem_waddr = ld_addr[IdxW+1:2];
    mem_wdata = ld_data;
    unique case (state_q)
      IMEM_CLEAR: begin
`ifdef IMEM_INIT_FILE_EN
        state_d = IMEM_READY;
`else
        mem_we    = 1'b1;
        mem_waddr = ptr_q;
        mem_wdata = FILL_WORD;
        if (ptr_q == IdxW'(DEPTH_WORDS - 1)) state_d = IMEM_READY;
`endif
      end
      IMEM_READY: mem_we = ld_we & ld_ok;
      default:    state_d = IMEM_CLEAR;
    endcase
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state_q    <= IMEM_CLEAR;
      valid_q    <= 1'b0;
      fault_q    <= 1'b0;
      fill_sel_q <= 1'b1;
    end else begin
      state_q <= state_d;
      if (!fetch_stall) begin
        valid_q <= accept;
        fault_q <= accept & ~fetch_ok;
        // Data mux selection only moves on a completed fetch so idle cycles hold the word.
        if (accept) fill_sel_q <= ~fetch_ok;
      end
    end
  end

  imem_word_array #(
    .DEPTH_WORDS(DEPTH_WORDS)
  ) u_array (
    .clk_i  (clk),
    .we_i   (mem_we),
    .waddr_i(mem_waddr),
    .wdata_i(mem_wdata),
    .re_i   (mem_re),
    .raddr_i(fetch_addr[IdxW+1:2]),
    .rdata_o(rdata)
  );

  always_comb begin
    if (fill_sel_q)           fetch_data = FILL_WORD;
    else if (BIG_ENDIAN != 0) fetch_data = rdata;
    else                      fetch_data = byte_swap32(rdata);
  end

  assign fetch_valid = valid_q;
  assign fetch_fault = fault_q;

endmodule

// File: tb/tb_imem_sync_rom.sv
// Directed bench for imem_sync_rom: vector table plus reset/clear sequences.
module tb_imem_sync_rom;

  localparam logic [31:0] Nop = 32'hE1A00000;

  logic        clk = 1'b0;
  logic        nreset;
  logic        fetch_req, fetch_stall, ld_we;
  logic [31:0] fetch_addr, ld_addr, ld_data;
  logic [31:0] fetch_data;
  logic        fetch_valid, fetch_fault, init_done;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  imem_sync_rom #(
    .DEPTH_WORDS(64),
    .ADDR_W     (32),
    .FILL_WORD  (Nop),
    .BIG_ENDIAN (1)
  ) dut (
    .clk        (clk),
    .nreset     (nreset),
    .fetch_req  (fetch_req),
    .fetch_addr (fetch_addr),
    .fetch_stall(fetch_stall),
    .fetch_data (fetch_data),
    .fetch_valid(fetch_valid),
    .fetch_fault(fetch_fault),
    .ld_we      (ld_we),
    .ld_addr    (ld_addr),
    .ld_data    (ld_data),
    .init_done  (init_done)
  );

  typedef struct {
    logic        req;
    logic        stall;
    logic [31:0] addr;
    logic        we;
    logic [31:0] la;
    logic [31:0] ld;
    logic        ev;
    logic        ef;
    logic [31:0] ed;
  } vec_t;

  localparam int NVec = 19;
  vec_t vecs [NVec];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    fetch_req = 1'b0; fetch_stall = 1'b0; fetch_addr = '0;
    ld_we = 1'b0; ld_addr = '0; ld_data = '0;
  endtask

  task automatic wait_init(input string name, input logic hold_load);
    int cycles = 0;
    while (!init_done && cycles < 200) begin
      if (hold_load) begin
        ld_we = 1'b1; ld_addr = 32'h10; ld_data = 32'hDEADBEEF;
      end
      step();
      cycles++;
    end
    ld_we = 1'b0;
    check(name, cycles, 64);
  endtask

  initial begin
    // {req, stall, addr, ld_we, ld_addr, ld_data, exp_valid, exp_fault, exp_data}
    vecs[0]  = '{1, 0, 32'h000, 0, 32'h000, 32'h0,        1, 0, Nop};
    vecs[1]  = '{0, 0, 32'h000, 1, 32'h004, 32'hE3A00008, 0, 0, Nop};
    vecs[2]  = '{1, 0, 32'h004, 0, 32'h000, 32'h0,        1, 0, 32'hE3A00008};
    vecs[3]  = '{1, 0, 32'h006, 0, 32'h000, 32'h0,        1, 1, Nop};
    vecs[4]  = '{0, 0, 32'h000, 1, 32'h000, 32'hE3A01001, 0, 0, Nop};
    vecs[5]  = '{1, 0, 32'h000, 0, 32'h000, 32'h0,        1, 0, 32'hE3A01001};
    vecs[6]  = '{1, 0, 32'h100, 0, 32'h000, 32'h0,        1, 1, Nop};
    vecs[7]  = '{1, 0, 32'h004, 0, 32'h000, 32'h0,        1, 0, 32'hE3A00008};
    vecs[8]  = '{1, 1, 32'h008, 0, 32'h000, 32'h0,        1, 0, 32'hE3A00008};
    vecs[9]  = '{1, 1, 32'h008, 0, 32'h000, 32'h0,        1, 0, 32'hE3A00008};
    vecs[10] = '{1, 1, 32'h008, 0, 32'h000, 32'h0,        1, 0, 32'hE3A00008};
    vecs[11] = '{0, 0, 32'h000, 0, 32'h000, 32'h0,        0, 0, 32'hE3A00008};
    vecs[12] = '{1, 0, 32'h008, 1, 32'h008, 32'hE5810000, 1, 0, Nop};
    vecs[13] = '{1, 0, 32'h008, 0, 32'h000, 32'h0,        1, 0, 32'hE5810000};
    vecs[14] = '{1, 0, 32'h0FC, 1, 32'h100, 32'hDEADBEEF, 1, 0, Nop};
    vecs[15] = '{1, 0, 32'h0FC, 0, 32'h000, 32'h0,        1, 0, Nop};
    vecs[16] = '{1, 0, 32'h000, 0, 32'h000, 32'h0,        1, 0, 32'hE3A01001};
    vecs[17] = '{0, 0, 32'h000, 1, 32'h00E, 32'hE0800001, 0, 0, 32'hE3A01001};
    vecs[18] = '{1, 0, 32'h00C, 0, 32'h000, 32'h0,        1, 0, 32'hE0800001};

    idle_inputs();
    nreset = 1'b0;
    step();
    step();
    check("rst_data", fetch_data, Nop);
    check("rst_valid", 32'(fetch_valid), 32'd0);
    check("rst_fault", 32'(fetch_fault), 32'd0);
    check("rst_init_done", 32'(init_done), 32'd0);

    nreset = 1'b1;
    wait_init("clear_cycles", 1'b0);

    for (int i = 0; i < NVec; i++) begin
      fetch_req = vecs[i].req; fetch_stall = vecs[i].stall; fetch_addr = vecs[i].addr;
      ld_we = vecs[i].we; ld_addr = vecs[i].la; ld_data = vecs[i].ld;
      step();
      check($sformatf("v%0d_valid", i), 32'(fetch_valid), 32'(vecs[i].ev));
      check($sformatf("v%0d_fault", i), 32'(fetch_fault), 32'(vecs[i].ef));
      check($sformatf("v%0d_data", i), fetch_data, vecs[i].ed);
    end

    // Reset mid-fetch, then mid-clear at ptr=20 with loads attempted throughout the clear.
    idle_inputs();
    fetch_req = 1'b1; fetch_addr = 32'h004;
    step();
    nreset = 1'b0;
    #1;
    check("midfetch_rst_valid", 32'(fetch_valid), 32'd0);
    check("midfetch_rst_data", fetch_data, Nop);
    check("midfetch_rst_init", 32'(init_done), 32'd0);
    idle_inputs();
    step();
    nreset = 1'b1;
    for (int i = 0; i < 20; i++) step();
    check("midclear_init_before", 32'(init_done), 32'd0);
    nreset = 1'b0;
    #1;
    check("midclear_rst_init", 32'(init_done), 32'd0);
    step();
    nreset = 1'b1;
    wait_init("reclear_cycles", 1'b1);

    fetch_req = 1'b1; fetch_addr = 32'h004;
    step();
    check("wiped_w1_valid", 32'(fetch_valid), 32'd1);
    check("wiped_w1_data", fetch_data, Nop);
    fetch_addr = 32'h010;
    step();
    check("clear_load_ignored", fetch_data, Nop);
    fetch_addr = 32'h000;
    step();
    check("wiped_w0_data", fetch_data, Nop);
    check("wiped_w0_fault", 32'(fetch_fault), 32'd0);
    idle_inputs();
    step();
    check("idle_valid", 32'(fetch_valid), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
